// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its inverse (fib_index).
package fib_pkg;

  localparam int FIB_W       = 20;
  localparam int IDX_W       = 5;
  localparam int FIB_MAX_IDX = 30;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OP   = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fib_index.sv
// Inverse Fibonacci: largest i with fib(i) <= f_in, plus an exact-match flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready=1, waiting for start; f_in captured on accept
// ST_OP   | walk t0/t1 up the sequence until t1 exceeds captured value
// ST_DONE | done_tick=1 for one cycle, i_out/exact valid
module fib_index
  import fib_pkg::*;
#(
  parameter int W = FIB_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     f_in,
  output logic [IDX_W-1:0] i_out,
  output logic             exact,
  output logic             ready,
  output logic             done_tick
);

  logic [1:0]       state_q, state_d;
  logic [W:0]       t0_q, t0_d;
  logic [W:0]       t1_q, t1_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [W-1:0]     fr_q, fr_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic             exact_q, exact_d;

  // t1 <= fr < 2^W whenever the sum is used, so W+1 bits cannot overflow
  logic [W:0] sum;
  logic       past;

  assign sum  = t0_q + t1_q;
  assign past = t1_q > {1'b0, fr_q};

  always_comb begin
    state_d = state_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    n_d     = n_q;
    fr_d    = fr_q;
    i_d     = i_q;
    exact_d = exact_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fr_d    = f_in;
          t0_d    = '0;
          t1_d    = (W+1)'(1);
          n_d     = '0;
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        if (past) begin
          i_d     = n_q;
          exact_d = (t0_q == {1'b0, fr_q});
          state_d = ST_DONE;
        end else begin
          t0_d = t1_q;
          t1_d = sum;
          n_d  = n_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      t0_q    <= '0;
      t1_q    <= '0;
      n_q     <= '0;
      fr_q    <= '0;
      i_q     <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      n_q     <= n_d;
      fr_q    <= fr_d;
      i_q     <= i_d;
      exact_q <= exact_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done_tick = (state_q == ST_DONE);
  assign i_out     = i_q;
  assign exact     = exact_q;

endmodule
